// File: rtl/jt51_acc_gen_pkg.sv
// ============================================================================
// jt51_acc_gen_pkg
// Shared constants and helpers for the jt51 output accumulator.
//   - default parameter values
//   - slot-index width derivation
//   - signed saturation range check
// Revision: 1.0
// ============================================================================
`default_nettype none

package jt51_acc_gen_pkg;

  localparam int DEF_OPW        = 14;
  localparam int DEF_OUTW       = 16;
  localparam int DEF_NSLOT      = 32;
  localparam int DEF_NOISE_SLOT = 31;
  localparam int NOISE_W        = 10;

  // Bits needed to index one slot of a frame (NSLOT is a power of two).
  function automatic int slot_w(input int nslot);
    return $clog2(nslot);
  endfunction

  // Range check of a sign-extended value against an outw-bit signed range.
  // Returns {above_max, below_min}.
  function automatic logic [1:0] sat_chk(input logic signed [63:0] v, input int outw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (outw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (outw - 1));
    return {v > hi, v < lo};
  endfunction

endpackage

`default_nettype wire

// File: rtl/jt51_acc_sat.sv
// ============================================================================
// jt51_acc_sat
// Combinational signed saturator from IW to OW bits.
// Ports:
//   din  in  IW  signed value
//   dout out OW  din clamped to the OW-bit signed range
// Revision: 1.0
// ============================================================================
`default_nettype none

module jt51_acc_sat
  import jt51_acc_gen_pkg::*;
#(
  parameter int IW = 19,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout
);

  generate
    if (IW > OW) begin : g_clamp
      logic signed [63:0] ext;
      logic [1:0]         ovf;

      assign ext = {{(64-IW){din[IW-1]}}, din};
      assign ovf = sat_chk(ext, OW);

      always_comb begin
        if (ovf[1])      dout = {1'b0, {(OW-1){1'b1}}};
        else if (ovf[0]) dout = {1'b1, {(OW-1){1'b0}}};
        else             dout = din[OW-1:0];
      end
    end else begin : g_extend
      // Output is at least as wide as the input: nothing can overflow.
      assign dout = OW'(din);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/jt51_acc_gen.sv
// ============================================================================
// jt51_acc_gen
// Per-frame left/right accumulator for jt51 operator outputs. Carrier slots
// are summed over a frame of NSLOT slots; on each frame start (zero=1) the
// finished sums are saturated to OUTW bits and presented on left/right with
// a one-cycle sample strobe. A slot counter checks frame alignment and
// raises a sticky sync_err.
// Optional build macro: JT51_ACC_NOISE_EN -- substitutes the noise sample
// (left-aligned) for op_out on slot NOISE_SLOT when ne=1.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   zero            cycle carries slot 0 of a frame
//   op_out [OPW]    signed operator output for the current slot
//   acc_en          current slot is a carrier
//   rl [2]          bit0 left enable, bit1 right enable
//   ne, noise [10]  noise enable and signed noise sample
//   left, right     saturated frame sums
//   sample          strobe when left/right update
//   sync_err        sticky frame-alignment error
// Revision: 1.0
// ============================================================================
`default_nettype none

module jt51_acc_gen
  import jt51_acc_gen_pkg::*;
#(
  parameter int OPW        = DEF_OPW,
  parameter int OUTW       = DEF_OUTW,
  parameter int NSLOT      = DEF_NSLOT,
  parameter int NOISE_SLOT = DEF_NOISE_SLOT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     zero,
  input  logic signed [OPW-1:0]    op_out,
  input  logic                     acc_en,
  input  logic [1:0]               rl,
  input  logic                     ne,
  input  logic signed [NOISE_W-1:0] noise,
  output logic signed [OUTW-1:0]   left,
  output logic signed [OUTW-1:0]   right,
  output logic                     sample,
  output logic                     sync_err
);

  localparam int SLW  = slot_w(NSLOT);
  localparam int ACCW = OPW + SLW;

  logic [SLW-1:0]         cnt;
  logic                   armed;
  logic signed [ACCW-1:0] acc_l;
  logic signed [ACCW-1:0] acc_r;
  logic signed [OPW-1:0]  op_val;
  logic signed [ACCW-1:0] op_ext;
  logic signed [ACCW-1:0] con_l;
  logic signed [ACCW-1:0] con_r;
  logic signed [OUTW-1:0] sat_l;
  logic signed [OUTW-1:0] sat_r;
  logic                   frame_err;

`ifdef JT51_ACC_NOISE_EN
  localparam logic [SLW-1:0] NOISE_IDX = SLW'(NOISE_SLOT);
  assign op_val = (ne && cnt == NOISE_IDX) ? {noise, {(OPW-NOISE_W){1'b0}}} : op_out;
`else
  logic unused_noise;
  assign unused_noise = ^{ne, noise};
  assign op_val       = op_out;
`endif

  assign op_ext = {{SLW{op_val[OPW-1]}}, op_val};
  assign con_l  = (acc_en && rl[0]) ? op_ext : '0;
  assign con_r  = (acc_en && rl[1]) ? op_ext : '0;

  // Alignment is only judged once the first frame start has been seen;
  // before that the counter free-runs from reset and means nothing.
  assign frame_err = armed && (zero ? (cnt != '0) : (cnt == '0));

  jt51_acc_sat #(.IW(ACCW), .OW(OUTW)) u_sat_l (.din(acc_l), .dout(sat_l));
  jt51_acc_sat #(.IW(ACCW), .OW(OUTW)) u_sat_r (.din(acc_r), .dout(sat_r));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      armed    <= 1'b0;
      acc_l    <= '0;
      acc_r    <= '0;
      left     <= '0;
      right    <= '0;
      sample   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      cnt    <= zero ? SLW'(1) : cnt + 1'b1;
      sample <= zero && armed;
      if (zero) armed <= 1'b1;
      if (frame_err) sync_err <= 1'b1;

      // The accumulator still holds the finished frame on the zero cycle,
      // so it is captured here while the new frame is loaded.
      if (zero && armed) begin
        left  <= sat_l;
        right <= sat_r;
      end

      if (zero) begin
        acc_l <= con_l;
        acc_r <= con_r;
      end else if (armed) begin
        acc_l <= acc_l + con_l;
        acc_r <= acc_r + con_r;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jt51_acc_gen.sv
// ============================================================================
// tb_jt51_acc_gen
// Directed self-checking bench for jt51_acc_gen (default parameters).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_jt51_acc_gen;

`ifdef JT51_ACC_NOISE_EN
  localparam int NOISE_EXP = 80;
`else
  localparam int NOISE_EXP = 3;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               zero;
  logic signed [13:0] op_out;
  logic               acc_en;
  logic [1:0]         rl;
  logic               ne;
  logic signed [9:0]  noise;
  logic signed [15:0] left;
  logic signed [15:0] right;
  logic               sample;
  logic               sync_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic signed [15:0] cap_l;
  logic signed [15:0] cap_r;
  logic               cap_s;
  logic               cap_s2;

  jt51_acc_gen dut (
    .clk      (clk),
    .rst      (rst),
    .zero     (zero),
    .op_out   (op_out),
    .acc_en   (acc_en),
    .rl       (rl),
    .ne       (ne),
    .noise    (noise),
    .left     (left),
    .right    (right),
    .sample   (sample),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives n slots starting with zero=1; slots c_lo..c_hi are carriers.
  // Captures the outputs right after the zero edge (closing the previous
  // frame) and the strobe one cycle later.
  task automatic do_frame(input int op, input logic [1:0] rlv, input int n,
                          input int c_lo, input int c_hi);
    for (int i = 0; i < n; i++) begin
      zero   = (i == 0);
      op_out = 14'(op);
      acc_en = (i >= c_lo && i <= c_hi);
      rl     = rlv;
      tick();
      if (i == 0) begin
        cap_l = left;
        cap_r = right;
        cap_s = sample;
      end
      if (i == 1) cap_s2 = sample;
    end
    zero   = 1'b0;
    acc_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; zero = 1'b0; op_out = '0; acc_en = 1'b0; rl = 2'b00;
    ne = 1'b0; noise = '0;
    tick(); tick();
    n_cmp++; if (left !== 16'sd0) begin n_bad++; $display("FAIL reset_left: got %0d expected 0", left); end
    n_cmp++; if (right !== 16'sd0) begin n_bad++; $display("FAIL reset_right: got %0d expected 0", right); end
    n_cmp++; if (sample !== 1'b0) begin n_bad++; $display("FAIL reset_sample: got %b expected 0", sample); end
    n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_arm();
    do_frame(100, 2'b11, 32, 0, 31);
    n_cmp++; if (cap_s !== 1'b0) begin n_bad++; $display("FAIL first_zero_sample: got %b expected 0", cap_s); end
  endtask

  task automatic test_sum();
    do_frame(8191, 2'b11, 32, 0, 31);
    n_cmp++; if (cap_l !== 16'sd3200) begin n_bad++; $display("FAIL sum_left: got %0d expected 3200", cap_l); end
    n_cmp++; if (cap_r !== 16'sd3200) begin n_bad++; $display("FAIL sum_right: got %0d expected 3200", cap_r); end
    n_cmp++; if (cap_s !== 1'b1) begin n_bad++; $display("FAIL sum_sample: got %b expected 1", cap_s); end
    n_cmp++; if (cap_s2 !== 1'b0) begin n_bad++; $display("FAIL sum_sample_width: got %b expected 0", cap_s2); end
  endtask

  task automatic test_sat();
    do_frame(-8192, 2'b11, 32, 0, 31);
    n_cmp++; if (cap_l !== 16'sd32767) begin n_bad++; $display("FAIL sat_pos_left: got %0d expected 32767", cap_l); end
    n_cmp++; if (cap_r !== 16'sd32767) begin n_bad++; $display("FAIL sat_pos_right: got %0d expected 32767", cap_r); end
    do_frame(50, 2'b01, 32, 0, 3);
    n_cmp++; if (cap_l !== -16'sd32768) begin n_bad++; $display("FAIL sat_neg_left: got %0d expected -32768", cap_l); end
    n_cmp++; if (cap_r !== -16'sd32768) begin n_bad++; $display("FAIL sat_neg_right: got %0d expected -32768", cap_r); end
  endtask

  task automatic test_rl();
    do_frame(0, 2'b00, 32, 0, -1);
    n_cmp++; if (cap_l !== 16'sd200) begin n_bad++; $display("FAIL rl_left: got %0d expected 200", cap_l); end
    n_cmp++; if (cap_r !== 16'sd0) begin n_bad++; $display("FAIL rl_right: got %0d expected 0", cap_r); end
    n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL aligned_sync_err: got %b expected 0", sync_err); end
  endtask

  task automatic test_early_zero();
    do_frame(10, 2'b11, 20, 0, 31);
    do_frame(7, 2'b11, 32, 0, 31);
    n_cmp++; if (cap_l !== 16'sd200) begin n_bad++; $display("FAIL early_left: got %0d expected 200", cap_l); end
    n_cmp++; if (cap_r !== 16'sd200) begin n_bad++; $display("FAIL early_right: got %0d expected 200", cap_r); end
    n_cmp++; if (cap_s !== 1'b1) begin n_bad++; $display("FAIL early_sample: got %b expected 1", cap_s); end
    n_cmp++; if (sync_err !== 1'b1) begin n_bad++; $display("FAIL early_sync_err: got %b expected 1", sync_err); end
  endtask

  task automatic test_reset_mid();
    int seen;
    do_frame(100, 2'b11, 10, 0, 31);
    n_cmp++; if (cap_l !== 16'sd224) begin n_bad++; $display("FAIL resync_left: got %0d expected 224", cap_l); end
    n_cmp++; if (sync_err !== 1'b1) begin n_bad++; $display("FAIL sticky_sync_err: got %b expected 1", sync_err); end
    rst = 1'b1;
    #1;
    n_cmp++; if (left !== 16'sd0) begin n_bad++; $display("FAIL async_rst_left: got %0d expected 0", left); end
    n_cmp++; if (right !== 16'sd0) begin n_bad++; $display("FAIL async_rst_right: got %0d expected 0", right); end
    n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL async_rst_sync_err: got %b expected 0", sync_err); end
    tick();
    rst = 1'b0;
    seen = 0;
    op_out = 14'sd100; acc_en = 1'b1; rl = 2'b11; zero = 1'b0;
    for (int i = 0; i < 22; i++) begin
      tick();
      if (sample === 1'b1) seen++;
    end
    acc_en = 1'b0;
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL unarmed_samples: got %0d expected 0", seen); end
    do_frame(100, 2'b11, 32, 0, 31);
    n_cmp++; if (cap_s !== 1'b0) begin n_bad++; $display("FAIL rearm_sample: got %b expected 0", cap_s); end
    do_frame(0, 2'b00, 32, 0, -1);
    n_cmp++; if (cap_l !== 16'sd3200) begin n_bad++; $display("FAIL post_rst_left: got %0d expected 3200", cap_l); end
    n_cmp++; if (cap_s !== 1'b1) begin n_bad++; $display("FAIL post_rst_sample: got %b expected 1", cap_s); end
    n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL post_rst_sync_err: got %b expected 0", sync_err); end
  endtask

  task automatic test_noise();
    ne    = 1'b1;
    noise = 10'sd5;
    do_frame(3, 2'b11, 32, 31, 31);
    ne    = 1'b0;
    do_frame(0, 2'b00, 32, 0, -1);
    n_cmp++; if (cap_l !== 16'(NOISE_EXP)) begin n_bad++; $display("FAIL noise_left: got %0d expected %0d", cap_l, NOISE_EXP); end
    n_cmp++; if (cap_r !== 16'(NOISE_EXP)) begin n_bad++; $display("FAIL noise_right: got %0d expected %0d", cap_r, NOISE_EXP); end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_sum();
    test_sat();
    test_rl();
    test_early_zero();
    test_reset_mid();
    test_noise();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
